// File: rtl/core_issue_ctrl_pkg.sv
// Shared types for the backend issue controller: instruction payload, FIFO head view,
// FSM state and the register scoreboard.
package core_issue_ctrl_pkg;

  localparam int unsigned NumRegs = 32;

  typedef enum logic [0:0] {RUN, HOLD} issue_state_e;

  typedef logic [NumRegs-1:0] scoreboard_t;
  typedef logic [4:0]         reg_idx_t;

  typedef struct packed {
    logic [31:0]    pc;
    logic [1:0]     fetch_excp;
    reg_idx_t       w_reg;
    reg_idx_t [1:0] r_reg;
  } inst_t;

  typedef struct packed {
    logic [1:0]  inst_valid;
    inst_t [1:0] inst;
  } frontend_req_t;

  typedef struct packed {
    logic [1:0] issue;
    logic       rst_jmp;
  } frontend_resp_t;

  // r0 never maps to a scoreboard bit.
  function automatic scoreboard_t reg_onehot(input reg_idx_t r, input logic en);
    scoreboard_t m;
    m = '0;
    if (en && (r != '0)) m[r] = 1'b1;
    return m;
  endfunction

  function automatic logic regs_clear(input inst_t i, input scoreboard_t eff);
    return !(eff[i.r_reg[0]] || eff[i.r_reg[1]] || eff[i.w_reg]);
  endfunction

endpackage

// File: rtl/core_issue_ctrl_if.sv
// FIFO-head handshake between the frontend instruction FIFO and the issue controller.
interface core_issue_ctrl_if;
  import core_issue_ctrl_pkg::*;

  frontend_req_t frontend_req;
  logic [1:0]    issue;

  modport master (output frontend_req, input issue);
  modport slave  (input frontend_req, output issue);
endinterface

// File: rtl/core_scoreboard.sv
// 32-entry register busy scoreboard with same-cycle writeback bypass into the query.
module core_scoreboard
  import core_issue_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush_i,
  input  logic [1:0]     set_i,
  input  reg_idx_t [1:0] set_reg_i,
  input  logic [1:0]     clr_i,
  input  reg_idx_t [1:0] clr_reg_i,
  output scoreboard_t    eff_o
);

  scoreboard_t busy_q, busy_d;
  scoreboard_t set_mask, clr_mask;

  always_comb begin
    set_mask = reg_onehot(set_reg_i[0], set_i[0]) | reg_onehot(set_reg_i[1], set_i[1]);
    clr_mask = reg_onehot(clr_reg_i[0], clr_i[0]) | reg_onehot(clr_reg_i[1], clr_i[1]);
    eff_o    = busy_q & ~clr_mask;
    // Set is ORed after the clear so a new writer keeps the register busy.
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else if (flush_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/core_issue_ctrl.sv
// In-order dual-issue controller: hazard check against the scoreboard, issue pipe register
// toward execute, and a HOLD state entered after an excepting instruction issues.
module core_issue_ctrl
  import core_issue_ctrl_pkg::*;
#(
  parameter bit DUAL_ISSUE = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  core_issue_ctrl_if.slave    fe,
  input  logic                ex_ready_i,
  output logic [1:0]          is_valid_o,
  output inst_t [1:0]         is_inst_o,
  input  logic [1:0]          wb_valid_i,
  input  reg_idx_t [1:0]      wb_reg_i,
  output logic                hold_o
);

  issue_state_e state_q;
  scoreboard_t  eff;
  inst_t        inst0, inst1;
  logic         go0, go1, intra_hazard;
  logic [1:0]   set_en;

  assign inst0 = fe.frontend_req.inst[0];
  assign inst1 = fe.frontend_req.inst[1];

  always_comb begin
    intra_hazard = (inst0.w_reg != '0) &&
                   ((inst0.w_reg == inst1.r_reg[0]) || (inst0.w_reg == inst1.r_reg[1]) ||
                    (inst0.w_reg == inst1.w_reg));
    go0 = rst_n && !flush_i && ex_ready_i && (state_q == RUN) &&
          fe.frontend_req.inst_valid[0] && regs_clear(inst0, eff);
    // An excepting instruction in either slot keeps the pair from issuing together.
    go1 = go0 && DUAL_ISSUE && fe.frontend_req.inst_valid[1] && regs_clear(inst1, eff) &&
          (inst0.fetch_excp == '0) && (inst1.fetch_excp == '0) && !intra_hazard;
    fe.issue = {go1, go0};
    set_en   = {go1, go0};
  end

  core_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_i),
    .set_i     (set_en),
    .set_reg_i ({inst1.w_reg, inst0.w_reg}),
    .clr_i     (wb_valid_i),
    .clr_reg_i (wb_reg_i),
    .eff_o     (eff)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      hold_o     <= 1'b0;
      is_valid_o <= '0;
    end else if (flush_i) begin
      state_q    <= RUN;
      hold_o     <= 1'b0;
      is_valid_o <= '0;
    end else begin
      if (ex_ready_i) is_valid_o <= {go1, go0};
      if (go0 && (inst0.fetch_excp != '0)) begin
        state_q <= HOLD;
        hold_o  <= 1'b1;
      end
    end
  end

  // Payload carries no reset; is_valid_o qualifies it.
  always_ff @(posedge clk) begin
    if (go0) is_inst_o <= fe.frontend_req.inst;
  end

endmodule

// File: tb/tb_core_issue_ctrl.sv
// Directed bench for core_issue_ctrl: dual-issue instance plus a single-issue instance
// driven with the same stimulus.
module tb_core_issue_ctrl;
  import core_issue_ctrl_pkg::*;

  logic           clk;
  logic           rst_n;
  logic           flush;
  logic           ex_ready;
  logic [1:0]     wb_valid;
  reg_idx_t [1:0] wb_reg;
  logic [1:0]     is_valid, is_valid_si;
  inst_t [1:0]    is_inst, is_inst_si;
  logic           hold, hold_si;

  int unsigned n_tests;
  int unsigned n_fail;

  core_issue_ctrl_if fe ();
  core_issue_ctrl_if fe_si ();
  assign fe_si.frontend_req = fe.frontend_req;

  core_issue_ctrl #(.DUAL_ISSUE(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .fe         (fe),
    .ex_ready_i (ex_ready),
    .is_valid_o (is_valid),
    .is_inst_o  (is_inst),
    .wb_valid_i (wb_valid),
    .wb_reg_i   (wb_reg),
    .hold_o     (hold)
  );

  core_issue_ctrl #(.DUAL_ISSUE(1'b0)) dut_si (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .fe         (fe_si),
    .ex_ready_i (ex_ready),
    .is_valid_o (is_valid_si),
    .is_inst_o  (is_inst_si),
    .wb_valid_i (wb_valid),
    .wb_reg_i   (wb_reg),
    .hold_o     (hold_si)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic inst_t mk(input logic [31:0] pc, input reg_idx_t w, input reg_idx_t r0,
                               input reg_idx_t r1, input logic [1:0] excp);
    inst_t i;
    i.pc         = pc;
    i.fetch_excp = excp;
    i.w_reg      = w;
    i.r_reg[0]   = r0;
    i.r_reg[1]   = r1;
    return i;
  endfunction

  task automatic head(input logic [1:0] v, input inst_t i0, input inst_t i1);
    fe.frontend_req.inst_valid = v;
    fe.frontend_req.inst[0]    = i0;
    fe.frontend_req.inst[1]    = i1;
    #1;
  endtask

  task automatic wb(input logic [1:0] v, input reg_idx_t r0, input reg_idx_t r1);
    wb_valid  = v;
    wb_reg[0] = r0;
    wb_reg[1] = r1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    ex_ready = 1'b0;
    wb(2'b00, 5'd0, 5'd0);
    head(2'b00, mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0));
    step();
    step();
    check_eq("rst_is_valid", is_valid, 2'b00);
    check_eq("rst_hold", hold, 0);
    check_eq("rst_busy", dut.u_scoreboard.busy_q, 0);
    rst_n    = 1'b1;
    ex_ready = 1'b1;

    // Independent pair
    head(2'b11, mk(32'h10, 1, 0, 0, 0), mk(32'h14, 2, 0, 0, 0));
    check_eq("pair_issue", fe.issue, 2'b11);
    step();
    check_eq("pair_is_valid", is_valid, 2'b11);
    check_eq("pair_busy", dut.u_scoreboard.busy_q, 32'h6);
    check_eq("pair_pc1", is_inst[1].pc, 32'h14);

    // Intra-pair RAW; writeback of r1/r2 bypasses into this check
    wb(2'b11, 5'd1, 5'd2);
    head(2'b11, mk(32'h20, 3, 1, 2, 0), mk(32'h24, 4, 3, 3, 0));
    check_eq("raw_issue", fe.issue, 2'b01);
    step();
    check_eq("raw_busy", dut.u_scoreboard.busy_q, 32'h8);
    wb(2'b00, 5'd0, 5'd0);
    head(2'b01, mk(32'h24, 4, 3, 3, 0), mk(0, 0, 0, 0, 0));
    for (int c = 0; c < 2; c++) begin
      check_eq("raw_stall", fe.issue, 2'b00);
      step();
    end
    check_eq("raw_stall_is_valid", is_valid, 2'b00);
    wb(2'b01, 5'd3, 5'd0);
    #1;
    check_eq("raw_bypass_issue", fe.issue, 2'b01);
    step();
    check_eq("raw_bypass_busy", dut.u_scoreboard.busy_q, 32'h10);

    // Set/clear collision on r5, r4 cleared via port 1
    wb(2'b00, 5'd0, 5'd0);
    head(2'b01, mk(32'h30, 5, 0, 0, 0), mk(0, 0, 0, 0, 0));
    check_eq("col_first_issue", fe.issue, 2'b01);
    step();
    check_eq("col_first_busy", dut.u_scoreboard.busy_q, 32'h30);
    wb(2'b11, 5'd5, 5'd4);
    head(2'b01, mk(32'h34, 5, 0, 0, 0), mk(0, 0, 0, 0, 0));
    check_eq("col_issue", fe.issue, 2'b01);
    step();
    check_eq("col_busy", dut.u_scoreboard.busy_q, 32'h20);

    // Backpressure
    wb(2'b00, 5'd0, 5'd0);
    head(2'b11, mk(32'h70, 7, 0, 0, 0), mk(32'h74, 9, 0, 0, 0));
    check_eq("bp_pre_issue", fe.issue, 2'b11);
    step();
    check_eq("bp_pre_busy", dut.u_scoreboard.busy_q, 32'h2A0);
    ex_ready = 1'b0;
    head(2'b11, mk(32'hA0, 10, 0, 0, 0), mk(32'hA4, 11, 0, 0, 0));
    for (int c = 0; c < 3; c++) begin
      wb((c == 0) ? 2'b01 : 2'b00, 5'd7, 5'd0);
      #1;
      check_eq("bp_issue", fe.issue, 2'b00);
      step();
      check_eq("bp_pc_stable", is_inst[0].pc, 32'h70);
      check_eq("bp_valid_hold", is_valid, 2'b11);
    end
    check_eq("bp_busy_after", dut.u_scoreboard.busy_q, 32'h220);
    wb(2'b00, 5'd0, 5'd0);
    ex_ready = 1'b1;
    #1;
    check_eq("bp_resume_issue", fe.issue, 2'b11);
    step();
    check_eq("bp_resume_busy", dut.u_scoreboard.busy_q, 32'hE20);

    // Exception issues alone then HOLD until flush
    head(2'b11, mk(32'hC0, 0, 0, 0, 2'd1), mk(32'hC4, 12, 0, 0, 0));
    check_eq("exc_issue", fe.issue, 2'b01);
    step();
    check_eq("exc_hold", hold, 1);
    check_eq("exc_busy", dut.u_scoreboard.busy_q, 32'hE20);
    head(2'b11, mk(32'hD0, 13, 0, 0, 0), mk(32'hD4, 14, 0, 0, 0));
    for (int c = 0; c < 10; c++) begin
      check_eq("hold_issue", fe.issue, 2'b00);
      check_eq("hold_level", hold, 1);
      step();
    end
    check_eq("hold_is_valid", is_valid, 2'b00);
    flush = 1'b1;
    wb(2'b01, 5'd12, 5'd0);
    #1;
    check_eq("flush_issue", fe.issue, 2'b00);
    step();
    flush = 1'b0;
    wb(2'b00, 5'd0, 5'd0);
    check_eq("flush_hold", hold, 0);
    check_eq("flush_busy", dut.u_scoreboard.busy_q, 0);
    check_eq("flush_is_valid", is_valid, 2'b00);

    // r0 as destination never forms an intra-pair hazard and never sets busy
    head(2'b11, mk(32'hE0, 0, 0, 0, 0), mk(32'hE4, 13, 0, 0, 0));
    check_eq("r0_issue", fe.issue, 2'b11);
    check_eq("si_r0_issue", fe_si.issue, 2'b01);
    step();
    check_eq("r0_busy", dut.u_scoreboard.busy_q, 32'h2000);
    check_eq("si_r0_busy", dut_si.u_scoreboard.busy_q, 0);

    // Single-issue build with independent pairs
    head(2'b11, mk(32'hF0, 14, 0, 0, 0), mk(32'hF4, 15, 0, 0, 0));
    check_eq("si_issue_a", fe_si.issue, 2'b01);
    check_eq("dual_issue_a", fe.issue, 2'b11);
    step();
    check_eq("si_is_valid", is_valid_si, 2'b01);
    head(2'b11, mk(32'hF8, 16, 0, 0, 0), mk(32'hFC, 17, 0, 0, 0));
    check_eq("si_issue_b", fe_si.issue, 2'b01);
    step();

    // Reset mid-operation dominates flush
    rst_n = 1'b0;
    flush = 1'b1;
    step();
    check_eq("rst2_busy", dut.u_scoreboard.busy_q, 0);
    check_eq("rst2_is_valid", is_valid, 2'b00);
    check_eq("rst2_hold", hold, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
